// File: rtl/stage_sequencer_pkg.sv
// Shared types and constants for the multi-cycle stage sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6,
    ST_FAULT   = 3'd7
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  // IDLE and the two terminal states are the only non-busy states.
  function automatic logic is_active(state_e s);
    return !(s inside {ST_IDLE, ST_HALT, ST_FAULT});
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Control bundle between the stage sequencer (master) and its datapath/memories (slave).
interface stage_sequencer_if;

  logic        start;
  logic        halt_req;
  logic        imem_ready;
  logic        dmem_ready;
  logic        branch;
  logic        alu_zero;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [63:0] immediate;

  logic [31:0] pc;
  logic        ir_en;
  logic        dmem_en;
  logic        rf_we;
  logic        retire;
  logic [2:0]  state;
  logic        busy;
  logic        fault;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  modport master (
    input  start, halt_req, imem_ready, dmem_ready,
    input  branch, alu_zero, mem_read, mem_write, reg_write, immediate,
    output pc, ir_en, dmem_en, rf_we, retire, state, busy, fault,
    output cycle_cnt, instret_cnt
  );

  modport slave (
    output start, halt_req, imem_ready, dmem_ready,
    output branch, alu_zero, mem_read, mem_write, reg_write, immediate,
    input  pc, ir_en, dmem_en, rf_we, retire, state, busy, fault,
    input  cycle_cnt, instret_cnt
  );

endinterface

// File: rtl/stage_sequencer_wait_timer.sv
// Counts consecutive not-ready cycles; expire_o fires on the (WAIT_MAX+1)-th one.
module wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(WAIT_MAX + 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (wait_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = wait_i && (cnt_q == CW'(WAIT_MAX));

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB controller with wait timeout and branch-alignment fault.
// Optional performance counters are built only when STAGE_SEQ_PERF_EN is defined.
module stage_sequencer
  import seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned WAIT_MAX = 15
) (
  input logic        clk,
  input logic        rst,
  stage_sequencer_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        waiting, expire, taken, misaligned, in_wb, busy;
  logic [31:0] target;
  logic        unused_imm_hi;

  assign unused_imm_hi = ^bus.immediate[63:32];

  assign taken      = bus.branch & bus.alu_zero;
  assign target     = pc_q + bus.immediate[31:0];
  assign misaligned = taken && (target[1:0] != 2'b00);
  assign waiting    = ((state_q == ST_FETCH) && !bus.imem_ready) ||
                      ((state_q == ST_MEM)   && !bus.dmem_ready);

  wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .wait_i   (waiting),
    .clear_i  (state_d != state_q),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d = ST_FETCH;
        pc_d    = RESET_PC;
      end
      ST_FETCH:   if (bus.imem_ready) state_d = ST_DECODE;
                  else if (expire)    state_d = ST_FAULT;
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = (bus.mem_read | bus.mem_write) ? ST_MEM : ST_WB;
      ST_MEM:     if (bus.dmem_ready) state_d = ST_WB;
                  else if (expire)    state_d = ST_FAULT;
      ST_WB: begin
        // A misaligned taken branch faults and leaves pc on the branch itself.
        if (misaligned) begin
          state_d = ST_FAULT;
        end else begin
          pc_d    = taken ? target : pc_q + PC_INC;
          state_d = bus.halt_req ? ST_HALT : ST_FETCH;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Retirement strobes are masked by reset so an abandoned WB never commits.
  assign in_wb       = rst && (state_q == ST_WB);
  assign busy        = is_active(state_q);
  assign bus.state   = state_q;
  assign bus.pc      = pc_q;
  assign bus.busy    = busy;
  assign bus.fault   = (state_q == ST_FAULT);
  assign bus.ir_en   = (state_q == ST_FETCH) && bus.imem_ready;
  assign bus.dmem_en = (state_q == ST_MEM);
  assign bus.rf_we   = in_wb && bus.reg_write;
  assign bus.retire  = in_wb && !misaligned;

`ifdef STAGE_SEQ_PERF_EN
  logic [31:0] cycle_cnt_q, instret_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (busy)       cycle_cnt_q   <= cycle_cnt_q + 32'd1;
      if (bus.retire) instret_cnt_q <= instret_cnt_q + 32'd1;
    end
  end

  assign bus.cycle_cnt   = cycle_cnt_q;
  assign bus.instret_cnt = instret_cnt_q;
`else
  assign bus.cycle_cnt   = '0;
  assign bus.instret_cnt = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: reset, ALU/load/branch timing, PC wrap, halt, reset abandon, faults.
module tb_stage_sequencer;
  import seq_pkg::*;

`ifdef STAGE_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stage_sequencer_if bus();

  stage_sequencer #(.RESET_PC(32'h0000_0000), .WAIT_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rfwe_n   = 0;
  int ret_n    = 0;
  int dmem_n   = 0;
  int w0, r0, d0;

  // Strobe tallies, sampled mid-cycle when inputs are stable.
  always @(negedge clk) begin
    if (bus.rf_we)   rfwe_n++;
    if (bus.retire)  ret_n++;
    if (bus.dmem_en) dmem_n++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic br, input logic z, input logic mr, input logic mw,
                           input logic rw, input logic [63:0] imm);
    bus.branch    = br;
    bus.alu_zero  = z;
    bus.mem_read  = mr;
    bus.mem_write = mw;
    bus.reg_write = rw;
    bus.immediate = imm;
  endtask

  initial begin
    rst            = 1'b0;
    bus.start      = 1'b1;
    bus.halt_req   = 1'b0;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    set_instr(0, 0, 0, 0, 0, 64'd0);
    step();
    step();

    // Reset state, with start held high to show reset wins.
    check("rst_state",   bus.state, 64'(ST_IDLE));
    check("rst_pc",      bus.pc, 64'h0);
    check("rst_busy",    bus.busy, 64'd0);
    check("rst_fault",   bus.fault, 64'd0);
    check("rst_rf_we",   bus.rf_we, 64'd0);
    check("rst_retire",  bus.retire, 64'd0);
    check("rst_cyc",     bus.cycle_cnt, 64'd0);
    check("rst_instret", bus.instret_cnt, 64'd0);

    // ADD-like instruction, all ready.
    rst = 1'b1;
    set_instr(0, 0, 0, 0, 1, 64'd0);
    step();
    check("add_fetch", bus.state, 64'(ST_FETCH));
    check("add_ir_en", bus.ir_en, 64'd1);
    check("add_busy",  bus.busy, 64'd1);
    bus.start = 1'b0;
    w0 = rfwe_n; r0 = ret_n;
    step(); check("add_decode", bus.state, 64'(ST_DECODE));
    check("add_ir_en_dec", bus.ir_en, 64'd0);
    step(); check("add_exec", bus.state, 64'(ST_EXECUTE));
    step(); check("add_wb", bus.state, 64'(ST_WB));
    check("add_rf_we", bus.rf_we, 64'd1);
    check("add_retire", bus.retire, 64'd1);
    step(); check("add_next_fetch", bus.state, 64'(ST_FETCH));
    check("add_pc", bus.pc, 64'h4);
    check("add_rfwe_cnt", 64'(rfwe_n - w0), 64'd1);
    check("add_ret_cnt", 64'(ret_n - r0), 64'd1);
    check("add_cyc", bus.cycle_cnt, PERF ? 64'd4 : 64'd0);
    check("add_instret", bus.instret_cnt, PERF ? 64'd1 : 64'd0);

    // Load with dmem_ready low for 3 MEM cycles: 8 cycles total.
    set_instr(0, 0, 1, 0, 1, 64'd0);
    bus.dmem_ready = 1'b0;
    d0 = dmem_n; r0 = ret_n;
    step(); check("ld_decode", bus.state, 64'(ST_DECODE));
    step(); check("ld_exec", bus.state, 64'(ST_EXECUTE));
    step(); check("ld_mem1", bus.state, 64'(ST_MEM));
    check("ld_dmem_en", bus.dmem_en, 64'd1);
    step(); check("ld_mem2", bus.state, 64'(ST_MEM));
    step(); check("ld_mem3", bus.state, 64'(ST_MEM));
    step(); check("ld_mem4", bus.state, 64'(ST_MEM));
    bus.dmem_ready = 1'b1;
    step(); check("ld_wb", bus.state, 64'(ST_WB));
    step(); check("ld_next_fetch", bus.state, 64'(ST_FETCH));
    check("ld_pc", bus.pc, 64'h8);
    check("ld_dmem_cycles", 64'(dmem_n - d0), 64'd4);
    check("ld_ret_cnt", 64'(ret_n - r0), 64'd1);
    check("ld_cyc", bus.cycle_cnt, PERF ? 64'd12 : 64'd0);
    check("ld_instret", bus.instret_cnt, PERF ? 64'd2 : 64'd0);

    // Fillers to reach pc=0x10, then branches and the 32-bit wrap.
    set_instr(0, 0, 0, 0, 0, 64'd0);
    repeat (4) step();
    check("fill_pc_c", bus.pc, 64'hC);
    repeat (4) step();
    check("fill_pc_10", bus.pc, 64'h10);
    set_instr(1, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8);
    repeat (3) step();
    check("br_wb", bus.state, 64'(ST_WB));
    check("br_rf_we", bus.rf_we, 64'd0);
    step(); check("br_taken_pc", bus.pc, 64'h8);
    set_instr(1, 1, 0, 0, 0, 64'd8);
    repeat (4) step();
    check("br_fwd_pc", bus.pc, 64'h10);
    set_instr(1, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8);
    repeat (4) step();
    check("br_not_taken_pc", bus.pc, 64'h14);
    set_instr(1, 1, 0, 0, 0, 64'h1234_5678_FFFF_FFE8);
    repeat (4) step();
    check("br_imm_low_pc", bus.pc, 64'hFFFF_FFFC);
    set_instr(0, 0, 0, 0, 0, 64'd0);
    repeat (4) step();
    check("pc_wrap", bus.pc, 64'h0);

    // halt_req outside WB is ignored; in WB it halts.
    step(); check("h_decode", bus.state, 64'(ST_DECODE));
    bus.halt_req = 1'b1;
    step(); bus.halt_req = 1'b0;
    step(); step();
    check("h_no_halt", bus.state, 64'(ST_FETCH));
    check("h_pc4", bus.pc, 64'h4);
    repeat (3) step();
    check("h_wb", bus.state, 64'(ST_WB));
    bus.halt_req = 1'b1;
    step(); bus.halt_req = 1'b0;
    check("h_halt", bus.state, 64'(ST_HALT));
    check("h_busy", bus.busy, 64'd0);
    check("h_pc8", bus.pc, 64'h8);
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    check("h_start_ignored", bus.state, 64'(ST_HALT));

    // Reset during MEM abandons the load.
    rst = 1'b0; step(); rst = 1'b1;
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    repeat (4) step();
    check("rm_pc4", bus.pc, 64'h4);
    set_instr(0, 0, 1, 0, 1, 64'd0);
    bus.dmem_ready = 1'b0;
    step(); step(); step();
    check("rm_mem", bus.state, 64'(ST_MEM));
    rst = 1'b0;
    r0 = ret_n;
    step();
    check("rm_idle", bus.state, 64'(ST_IDLE));
    check("rm_pc", bus.pc, 64'h0);
    check("rm_dmem_en", bus.dmem_en, 64'd0);
    check("rm_no_retire", 64'(ret_n - r0), 64'd0);

    // Reset during WB suppresses the write and retire strobes.
    rst = 1'b1;
    bus.dmem_ready = 1'b1;
    set_instr(0, 0, 0, 0, 1, 64'd0);
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    step(); step(); step();
    check("rw_wb", bus.state, 64'(ST_WB));
    rst = 1'b0;
    w0 = rfwe_n; r0 = ret_n;
    #1;
    check("rw_rf_we", bus.rf_we, 64'd0);
    check("rw_retire", bus.retire, 64'd0);
    step();
    check("rw_idle", bus.state, 64'(ST_IDLE));
    check("rw_no_strobes", 64'((rfwe_n - w0) + (ret_n - r0)), 64'd0);

    // Misaligned taken branch with simultaneous halt_req -> FAULT, pc held.
    rst = 1'b1;
    set_instr(0, 0, 0, 0, 0, 64'd0);
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    repeat (4) step();
    set_instr(1, 1, 0, 0, 0, 64'd6);
    repeat (3) step();
    bus.halt_req = 1'b1;
    step(); bus.halt_req = 1'b0;
    check("mis_fault_state", bus.state, 64'(ST_FAULT));
    check("mis_fault", bus.fault, 64'd1);
    check("mis_busy", bus.busy, 64'd0);
    check("mis_pc_hold", bus.pc, 64'h4);

    // imem_ready stuck low: FAULT after 16 wait cycles.
    rst = 1'b0; step(); rst = 1'b1;
    set_instr(0, 0, 0, 0, 0, 64'd0);
    bus.imem_ready = 1'b0;
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    check("to_fetch", bus.state, 64'(ST_FETCH));
    check("to_ir_en", bus.ir_en, 64'd0);
    for (int i = 0; i < 15; i++) begin
      step();
      check("to_still_fetch", bus.state, 64'(ST_FETCH));
    end
    step();
    check("to_fault_state", bus.state, 64'(ST_FAULT));
    check("to_fault", bus.fault, 64'd1);
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    check("to_start_ignored", bus.state, 64'(ST_FAULT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded when `start` is accepted in IDLE.
REQ-002 Parameter WAIT_MAX, default 15, the largest number of consecutive not-ready cycles tolerated in FETCH or MEM.
REQ-003 Port `clk`, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 Port `rst`, input, width 1: synchronous, active-low reset.
REQ-005 Port `start`, input, width 1: begin execution; honoured only in IDLE.
REQ-006 Port `halt_req`, input, width 1: stop after the current instruction retires.
REQ-007 Port `imem_ready`, input, width 1: instruction memory holds valid data.
REQ-008 Port `dmem_ready`, input, width 1: data memory access is complete.
REQ-009 Port group, inputs: `branch` (1), `alu_zero` (1), `mem_read` (1), `mem_write` (1), `reg_write` (1), `immediate` (64); these are the decoder/ALU outputs for the current instruction.
REQ-010 Port `pc`, output, width 32: current program counter.
REQ-011 Port `ir_en`, output, width 1: one-cycle pulse that latches the fetched instruction.
REQ-012 Port `dmem_en`, output, width 1: asserted for every cycle spent in MEM.
REQ-013 Port `rf_we`, output, width 1: one-cycle register-file write strobe.
REQ-014 Port `retire`, output, width 1: one-cycle pulse when an instruction completes.
REQ-015 Port group, outputs: `state` (3), `busy` (1), `fault` (1); `busy` is high when `state` is not IDLE, HALT or FAULT.
REQ-016 Port group, outputs: `cycle_cnt` (32), `instret_cnt` (32).

Function
REQ-017 States and transitions:
- IDLE→FETCH on `start`.
- FETCH→DECODE when `imem_ready`.
- DECODE→EXECUTE unconditionally.
- EXECUTE→MEM if `mem_read|mem_write`, else EXECUTE→WB.
- MEM→WB when `dmem_ready`.
- WB→FETCH, or WB→HALT if `halt_req`.
REQ-018 `ir_en` shall pulse in the FETCH cycle where `imem_ready`=1.
REQ-019 `rf_we` and `retire` shall pulse only in WB; `rf_we` equals `reg_write`.
REQ-020 Latency: an ALU or branch instruction takes 4 cycles; a load or store takes 5 cycles; each not-ready cycle adds 1.
REQ-021 In WB, PC updates as follows:
- `pc` <= `pc` + `immediate[31:0]` when `branch & alu_zero`.
- otherwise `pc` <= `pc`+4.
- the sum is modulo 2^32, so 32'hFFFF_FFFC+4 gives 0.
REQ-022 A taken-branch target with bits [1:0]≠0 shall go to FAULT instead of FETCH or HALT, and `pc` holds the branching instruction's address.
REQ-023 A wait counter increments per not-ready cycle in FETCH or MEM and clears on a state change; reaching WAIT_MAX+1 shall go to FAULT.
REQ-024 Fault beats halt: if a fault condition and `halt_req` occur in the same cycle, the next state is FAULT.
REQ-025 HALT and FAULT are terminal; only `rst` leaves them, and `start` is ignored there.
REQ-026 `halt_req` is sampled only in WB; a pulse at any other time has no effect.

Reset
REQ-027 While `rst`=0 at a clock edge, the next state shall be:
- `state`=IDLE
- `pc`=RESET_PC
- wait counter=0
- `cycle_cnt`=0 and `instret_cnt`=0
- all strobes, `busy` and `fault` = 0
REQ-028 Reset mid-instruction shall abandon it with no `rf_we`/`retire` pulse in that cycle; reset wins over all inputs.

Configuration
REQ-029 With macro STAGE_SEQ_PERF_EN defined:
- `cycle_cnt` increments every cycle while `busy`.
- `instret_cnt` increments on `retire`.
- both wrap at 2^32.
REQ-030 Without STAGE_SEQ_PERF_EN, both counter ports shall still exist, be tied to 0, and no counter flops shall be instantiated.

Structure
REQ-031 Package `seq_pkg` shall hold:
- the 3-bit state encoding (IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6, FAULT=7)
- the default RESET_PC
- the PC increment constant 4
REQ-032 The wait counter plus its timeout compare shall be a single sub-module, `wait_timer`.

Verification
REQ-033 Reset, `start`, an ADD-like instruction (no memory access, `reg_write`=1), ready always high → FETCH..WB in 4 cycles, one `rf_we`, `pc`=4, `instret_cnt`=1.
REQ-034 Load with `dmem_ready` low 3 cycles → 8 cycles total, `dmem_en` high 4 cycles, `retire` once.
REQ-035 Branch with `alu_zero`=1 and `immediate`=-8 at `pc`=0x10 → `pc`=0x08; same branch with `alu_zero`=0 → `pc`=0x14.
REQ-036 `imem_ready` held low with WAIT_MAX=15 → FAULT after 16 wait cycles, `fault`=1, `start` ignored.
REQ-037 `halt_req` asserted in DECODE only → no halt; asserted in WB → HALT, with `busy`=0.
REQ-038 `rst` low during MEM → IDLE next cycle, `pc`=RESET_PC, no `retire` pulse.
